// File: rtl/icache_pkg.sv
// -----------------------------------------------------------------------------
// icache_pkg
// Shared types and constants for the instruction cache.
//   ICACHE_INDEX_W : default number of index bits (LINES = 2**ICACHE_INDEX_W)
//   inst_addr_t    : 32-bit instruction address
//   inst_t         : 32-bit instruction word
//   IC_IDLE/IC_MISS: controller state encodings
// -----------------------------------------------------------------------------
package icache_pkg;

    localparam int ICACHE_INDEX_W = 6;

    typedef logic [31:0] inst_addr_t;
    typedef logic [31:0] inst_t;

    localparam logic [0:0] IC_IDLE = 1'b0;
    localparam logic [0:0] IC_MISS = 1'b1;

endpackage

// File: rtl/icache_if.sv
// -----------------------------------------------------------------------------
// icache_if
// Bundles the IF-stage request/response signals and the mem_ctrl fetch
// signals seen by the instruction cache.
//   slave  : the cache side (takes requests, returns instructions, drives
//            the fetch request toward mem_ctrl)
//   master : the environment side (IF stage + mem_ctrl)
// -----------------------------------------------------------------------------
interface icache_if;
    import icache_pkg::*;

    logic       if_req;
    inst_addr_t if_pc;
    logic       flush;
    logic       inv;
    logic       inst_ok;
    inst_t      inst;
    inst_addr_t inst_pc;
    logic       mc_fe;
    inst_addr_t mc_fpc;
    logic       mc_ok;
    inst_addr_t mc_pc;
    inst_t      mc_inst;

    modport slave (
        input  if_req, if_pc, flush, inv, mc_ok, mc_pc, mc_inst,
        output inst_ok, inst, inst_pc, mc_fe, mc_fpc
    );

    modport master (
        output if_req, if_pc, flush, inv, mc_ok, mc_pc, mc_inst,
        input  inst_ok, inst, inst_pc, mc_fe, mc_fpc
    );
endinterface

// File: rtl/icache_array.sv
// -----------------------------------------------------------------------------
// icache_array
// Storage for the direct-mapped cache: valid bits, tag RAM and data RAM.
//   clk, rst      : clock, asynchronous active-low reset (valid bits only)
//   clr           : clear every valid bit on the next edge (wins over write)
//   we/widx/wtag/wdata : single write port, sets the line valid
//   ridx          : combinational read port index
//   rvalid/rtag/rdata  : read port outputs
// -----------------------------------------------------------------------------
module icache_array
    import icache_pkg::*;
#(
    parameter int INDEX_W = ICACHE_INDEX_W,
    parameter int TAG_W   = 16 - INDEX_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               we,
    input  logic [INDEX_W-1:0] widx,
    input  logic [TAG_W-1:0]   wtag,
    input  inst_t              wdata,
    input  logic [INDEX_W-1:0] ridx,
    output logic               rvalid,
    output logic [TAG_W-1:0]   rtag,
    output inst_t              rdata
);
    localparam int LINES = 2 ** INDEX_W;

    logic [LINES-1:0] valid;
    logic [TAG_W-1:0] tag_mem  [LINES];
    inst_t            data_mem [LINES];

    // Clear-all has priority so an invalidate coinciding with a fill leaves
    // the filled line invalid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= '0;
        end else if (clr) begin
            valid <= '0;
        end else if (we) begin
            valid[widx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            tag_mem[widx]  <= wtag;
            data_mem[widx] <= wdata;
        end
    end

    assign rvalid = valid[ridx];
    assign rtag   = tag_mem[ridx];
    assign rdata  = data_mem[ridx];

endmodule

// File: rtl/icache.sv
// -----------------------------------------------------------------------------
// icache
// Direct-mapped, one-word-per-line instruction cache between IF and mem_ctrl.
//   clk  : system clock
//   rst  : asynchronous reset, active-low
//   rdy  : pause; when low all state and output registers hold
//   bus  : icache_if.slave -- IF request/response and mem_ctrl fetch signals
// Hits answer one cycle after acceptance; misses answer one cycle after the
// matching mem_ctrl completion.
// -----------------------------------------------------------------------------
module icache
    import icache_pkg::*;
#(
    parameter int INDEX_W = ICACHE_INDEX_W,
    parameter int TAG_W   = 16 - INDEX_W
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      rdy,
    icache_if.slave   bus
);
    logic [0:0]         state;
    inst_addr_t         pc_q;
    logic               ok_q;
    logic               drop;
    inst_t              inst_q;
    inst_addr_t         inst_pc_q;
    logic               fe_q;
    inst_addr_t         fpc_q;

    logic [INDEX_W-1:0] req_idx;
    logic [TAG_W-1:0]   req_tag;
    logic [INDEX_W-1:0] fill_idx;
    logic [TAG_W-1:0]   fill_tag;
    logic               rvalid;
    logic [TAG_W-1:0]   rtag;
    inst_t              rdata;
    logic               hit;
    logic               accept;
    logic               fill;

    assign req_idx  = bus.if_pc[INDEX_W+1:2];
    assign req_tag  = bus.if_pc[17:INDEX_W+2];
    assign fill_idx = pc_q[INDEX_W+1:2];
    assign fill_tag = pc_q[17:INDEX_W+2];

    assign hit    = rvalid && (rtag == req_tag);
    assign accept = (state == IC_IDLE) && bus.if_req && !bus.flush;
    assign fill   = (state == IC_MISS) && bus.mc_ok && (bus.mc_pc == pc_q);

    icache_array #(
        .INDEX_W (INDEX_W),
        .TAG_W   (TAG_W)
    ) u_array (
        .clk    (clk),
        .rst    (rst),
        .clr    (rdy && bus.inv),
        .we     (rdy && fill),
        .widx   (fill_idx),
        .wtag   (fill_tag),
        .wdata  (bus.mc_inst),
        .ridx   (req_idx),
        .rvalid (rvalid),
        .rtag   (rtag),
        .rdata  (rdata)
    );

    // Controller. The response pulse (ok_q) defaults low each active cycle
    // and is raised only by a hit or by the completing fill. A flush seen on
    // the completing edge cancels the response just like an earlier flush.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IC_IDLE;
            pc_q      <= '0;
            ok_q      <= 1'b0;
            drop      <= 1'b0;
            inst_q    <= '0;
            inst_pc_q <= '0;
            fe_q      <= 1'b0;
            fpc_q     <= '0;
        end else if (rdy) begin
            ok_q <= 1'b0;
            if (state == IC_IDLE) begin
                if (accept) begin
                    pc_q <= bus.if_pc;
                    if (hit) begin
                        ok_q      <= 1'b1;
                        inst_q    <= rdata;
                        inst_pc_q <= bus.if_pc;
                    end else begin
                        state <= IC_MISS;
                        fe_q  <= 1'b1;
                        fpc_q <= bus.if_pc;
                    end
                end
            end else begin
                if (fill) begin
                    state     <= IC_IDLE;
                    fe_q      <= 1'b0;
                    ok_q      <= ~(drop | bus.flush);
                    inst_q    <= bus.mc_inst;
                    inst_pc_q <= pc_q;
                    drop      <= 1'b0;
                end else if (bus.flush) begin
                    drop <= 1'b1;
                end
            end
        end
    end

    assign bus.inst_ok = ok_q & ~bus.flush;
    assign bus.inst    = inst_q;
    assign bus.inst_pc = inst_pc_q;
    assign bus.mc_fe   = fe_q;
    assign bus.mc_fpc  = fpc_q;

endmodule

// File: doc/icache.md
Name: icache

Overview:
- Direct-mapped, one-word-per-line instruction cache between the IF stage and mem_ctrl.
- IF issues fetch requests by PC. Hits return in one cycle.
- Misses issue a word fetch to mem_ctrl, fill the line and return the instruction.
- Supports branch flush (drop the pending response) and whole-cache invalidate.

Parameters:
- INDEX_W, 6, index bits. LINES = 2**INDEX_W. Tag width TAG_W = 16 - INDEX_W, covering pc[17:INDEX_W+2].

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low
- rdy  in  1  pause: when low, all state and outputs freeze
- if_req  in  1  fetch request from IF
- if_pc  in  32  fetch address, word-aligned (pc[1:0] ignored)
- flush  in  1  branch taken in EX; cancels the outstanding request
- inv  in  1  invalidate all lines
- inst_ok  out  1  instruction valid, one-cycle pulse
- inst  out  32  returned instruction
- inst_pc  out  32  PC of the returned instruction
- mc_fe  out  1  fetch enable to mem_ctrl
- mc_fpc  out  32  fetch address to mem_ctrl
- mc_ok  in  1  mem_ctrl word complete
- mc_pc  in  32  address of the completed word
- mc_inst  in  32  fetched word

Behaviour:
- Address split:
  - index = pc[INDEX_W+1:2]
  - tag = pc[17:INDEX_W+2]
  - pc[31:18] is not compared.
- Reset (rst low, async):
  - all valid bits = 0, state = IDLE
  - ok_q, inst, inst_pc, mc_fe, mc_fpc = 0
  - drop = 0
  - Reset mid-miss abandons the fill.
- States are IDLE and MISS. All transitions happen only on clock edges with rdy = 1.
- IDLE:
  - Accepts if_req every cycle, so back-to-back requests are allowed.
  - On accept, latch pc_q = if_pc.
  - Hit (valid[index] and tag match): next cycle ok_q = 1, inst = data[index], inst_pc = pc_q. Stay in IDLE.
  - Miss: go to MISS. ok_q = 0.
  - if_req together with flush in the same cycle: the request is not accepted.
- MISS:
  - mc_fe = 1 and mc_fpc = pc_q are registered and held until fill.
  - if_req is ignored; IF holds its request.
  - mc_ok with mc_pc != pc_q is ignored.
  - mc_ok with mc_pc == pc_q:
    - write valid/tag/data at index(pc_q)
    - mc_fe drops to 0 next cycle
    - go to IDLE
    - ok_q = ~drop, inst = mc_inst, inst_pc = pc_q
    - clear drop
  - flush while in MISS: set drop = 1, keep waiting. mem_ctrl cannot abort, so the line is still filled but no response is given.
- Output gating: inst_ok = ok_q & ~flush (combinational). A response landing in a flush cycle is discarded.
- Response latency:
  - hit: 1 cycle after acceptance
  - miss: 1 cycle after the matching mc_ok
- inv:
  - Clears all valid bits at the next edge.
  - inv together with a fill on the same edge: inv wins, so the line ends invalid. The response itself is still delivered.
  - inv together with a hit lookup on the same edge: the lookup uses pre-clear valid bits.
- rdy low: no state, array or output register changes. inst_ok and mc_fe hold their values.
- Width: compare exactly TAG_W bits. The data array is 32 bits per line, no byte-level access.

Decomposition:
- defines.v additions:
  - `ICacheIndexW (default 6)
  - `ICacheTagW
  - state encodings `IcIdle / `IcMiss
  - reuse `InstAddrBus and `InstBus
- Sub-module icache_array:
  - valid bit vector with a single-cycle clear-all
  - tag RAM and data RAM
  - one combinational read port and one write port
- The FSM, drop bit and output registers stay in icache.

Test Plan:
- Cold miss: if_req with pc 0x00000104 → next cycle mc_fe = 1, mc_fpc = 0x104. Then mc_ok, mc_pc = 0x104, mc_inst = 0x00500093 → next cycle inst_ok pulse, inst = 0x00500093, inst_pc = 0x104. Re-request 0x104 → inst_ok after 1 cycle, mc_fe stays 0.
- Conflict: after filling 0x104, request 0x10104 (same index 1, different tag) → miss, mc_fpc = 0x10104. Fill 0x00A00113. Then 0x104 misses again.
- Flush during miss: request 0x200, assert flush while in MISS, complete mc_ok with 0x200 → no inst_ok. A following request for 0x200 hits in 1 cycle.
- Stray completion and pause: in MISS with pc_q = 0x300, mc_ok with mc_pc = 0x2FC → ignored, still MISS. Drop rdy for 3 cycles → mc_fe/mc_fpc held, no state change. Then matching mc_ok → response.
- inv coincident with a fill of 0x104 → inst_ok delivered. A subsequent 0x104 request misses.
- Async reset asserted mid-miss with no clock edge → mc_fe = 0 and inst_ok = 0 immediately. After release, a prior hit address misses.
